// File: rtl/dff_bank_arbiter_pkg.sv
// Shared types and the round-robin search helper for the dff_bank_arbiter slice.
package dff_bank_arbiter_pkg;

  localparam int MAX_NREQ = 8;
  localparam int IDX_W    = 3;

  typedef enum logic {IDLE, OWN} arb_state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // Scans from last+1 upward and wraps, so the previous owner is considered last.
  function automatic rr_pick_t rr_search(input logic [MAX_NREQ-1:0] req_vec,
                                         input logic [IDX_W-1:0]    last,
                                         input int unsigned         nreq);
    rr_pick_t         pick;
    logic [IDX_W-1:0] cand;
    pick = '0;
    for (int unsigned k = 1; k <= MAX_NREQ; k++) begin
      cand = IDX_W'((32'(last) + k) % nreq);
      if (k <= nreq && !pick.found && req_vec[cand]) begin
        pick.found = 1'b1;
        pick.idx   = cand;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// Requester-facing bus of the arbiter: requests and data in, grant and register contents out.
interface dff_bank_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  localparam int OW = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] wdata;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      q;
  logic              q_valid;
  logic [OW-1:0]     owner;

  modport master (output req, wdata, input gnt, q, q_valid, owner);
  modport slave  (input req, wdata, output gnt, q, q_valid, owner);

endinterface

// File: rtl/dff_bank_arbiter_reg_bank.sv
// W-bit shared state register with synchronous active-low reset and write enable.
module dff_reg_bank #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter that grants one writer at a time to the shared register,
// forcing a handoff after MAX_BURST consecutive writes.
module dff_bank_arbiter #(
  parameter int NREQ      = 4,
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  dff_bank_arbiter_if.slave  arb
);
  import dff_bank_arbiter_pkg::*;

  localparam int OW = $clog2(NREQ);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_t            state, state_n;
  logic [OW-1:0]         owner_r, owner_n;
  logic [NREQ-1:0]       gnt_r, gnt_n;
  logic [BW-1:0]         burst_cnt, burst_n;
  logic                  q_valid_r;
  logic                  we, release_c, arbitrate;
  logic [MAX_NREQ-1:0]   req_ext;
  logic [W-1:0]          wdata_sel;
  rr_pick_t              pick;

  assign we        = gnt_r[owner_r] & arb.req[owner_r];
  assign release_c = (state == OWN) &&
                     (!arb.req[owner_r] || (we && burst_cnt == BW'(MAX_BURST - 1)));
  assign arbitrate = (state == IDLE) || release_c;
  assign wdata_sel = arb.wdata[owner_r*W +: W];

  always_comb begin
    req_ext            = '0;
    req_ext[NREQ-1:0]  = arb.req;
  end

  assign pick = rr_search(req_ext, IDX_W'(owner_r), NREQ);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      owner_r   <= OW'(NREQ - 1);
      gnt_r     <= '0;
      burst_cnt <= '0;
      q_valid_r <= 1'b0;
    end else begin
      state     <= state_n;
      owner_r   <= owner_n;
      gnt_r     <= gnt_n;
      burst_cnt <= burst_n;
      if (we) q_valid_r <= 1'b1;
    end
  end

  // A release and a fresh grant land on the same edge, so handoffs never leave an idle cycle.
  always_comb begin
    state_n = state;
    owner_n = owner_r;
    gnt_n   = gnt_r;
    burst_n = burst_cnt;
    if (we) burst_n = burst_cnt + 1'b1;
    if (arbitrate) begin
      if (pick.found) begin
        state_n                  = OWN;
        owner_n                  = pick.idx[OW-1:0];
        gnt_n                    = '0;
        gnt_n[pick.idx[OW-1:0]]  = 1'b1;
        burst_n                  = '0;
      end else begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    end
  end

  dff_reg_bank #(.W(W)) u_bank (
    .clk   (clk),
    .reset (reset),
    .en    (we),
    .d     (wdata_sel),
    .q     (arb.q)
  );

  assign arb.gnt     = gnt_r;
  assign arb.owner   = owner_r;
  assign arb.q_valid = q_valid_r;

endmodule
